// File: rtl/apb_timer_completer.sv
// rtl/apb_timer_completer.sv - APB completer with 64-bit timer, compare register and level interrupt
module apb_timer_completer #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned TICK_DIV    = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_paddr,
   input  logic        in_psel,
   input  logic        in_penable,
   input  logic [2:0]  in_pprot,
   input  logic        in_pwrite,
   input  logic [31:0] in_pwdata,
   input  logic [3:0]  in_pstrb,
   output logic        in_pready,
   output logic [31:0] in_prdata,
   output logic        in_pslverr,
   output logic        irq
);

   // Register offsets, word index taken from paddr[4:2]
   localparam logic [2:0] OFF_MTIME_LO = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI = 3'd1;
   localparam logic [2:0] OFF_CMP_LO   = 3'd2;
   localparam logic [2:0] OFF_CMP_HI   = 3'd3;
   localparam logic [2:0] OFF_CTRL     = 3'd4;
   localparam logic [2:0] OFF_STATUS   = 3'd5;

   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
   localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  wait_cnt;
   logic [3:0]  wait_cnt_next;

   logic [63:0] mtime;
   logic [63:0] mtime_next;
   logic [63:0] mtime_inc;
   logic [63:0] mtimecmp;
   logic [63:0] mtimecmp_next;
   logic [1:0]  ctrl;
   logic [1:0]  ctrl_next;
   logic        pending;
   logic        pending_next;
   logic [31:0] hi_shadow;
   logic [31:0] hi_shadow_next;
   logic [15:0] presc;
   logic [15:0] presc_next;

   logic        done;
   logic [2:0]  offset;
   logic        addr_err;
   logic        wr_commit;
   logic        rd_commit;
   logic        tick;
   logic        cmp_hit;
   logic        w1c;
   logic [31:0] rdata;

   // Address bits and protection attributes that the register map does not decode
   logic        unused_inputs;
   assign unused_inputs = ^{in_pprot, in_paddr[31:5]};

   function automatic logic [31:0] merge_bytes(
      input logic [31:0] old_word,
      input logic [31:0] new_word,
      input logic [3:0]  strb
   );
      logic [31:0] result;
      for (int i = 0; i < 4; i++) begin
         result[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return result;
   endfunction

   // A transfer completes only while the initiator still holds psel in DONE
   assign done      = (state == ST_DONE) && in_psel;
   assign offset    = in_paddr[4:2];
   assign addr_err  = (in_paddr[1:0] != 2'b00) || (offset[2:1] == 2'b11);
   assign wr_commit = done && in_pwrite && !addr_err;
   assign rd_commit = done && !in_pwrite && !addr_err;

   assign in_pready  = done;
   assign in_pslverr = done && addr_err;
   assign in_prdata  = rd_commit ? rdata : 32'h0;

   assign tick    = ctrl[0] && (presc == PRESC_MAX);
   assign cmp_hit = ctrl[0] && (mtime >= mtimecmp);
   assign w1c     = wr_commit && (offset == OFF_STATUS) && in_pstrb[0] && in_pwdata[0];

   // Transfer FSM: setup loads the wait count, WAIT counts down, DONE completes
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      case (state)
         ST_IDLE: begin
            if (in_psel && !in_penable) begin
               wait_cnt_next = WAIT_LOAD;
               state_next    = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!in_psel) begin
               state_next = ST_IDLE;
            end else begin
               wait_cnt_next = wait_cnt - 4'd1;
               if (wait_cnt <= 4'd1) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // FSM state and wait counter registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Read mux; MTIME_HI returns the value captured by the last MTIME_LO read
   always_comb begin
      rdata = 32'h0;
      case (offset)
         OFF_MTIME_LO: rdata = mtime[31:0];
         OFF_MTIME_HI: rdata = hi_shadow;
         OFF_CMP_LO:   rdata = mtimecmp[31:0];
         OFF_CMP_HI:   rdata = mtimecmp[63:32];
         OFF_CTRL:     rdata = {30'h0, ctrl};
         OFF_STATUS:   rdata = {31'h0, pending};
         default:      rdata = 32'h0;
      endcase
   end

   // Timer, compare and register updates; a bus write overrides only its own bytes
   always_comb begin
      presc_next     = presc;
      mtime_inc      = tick ? (mtime + 64'd1) : mtime;
      mtime_next     = mtime_inc;
      mtimecmp_next  = mtimecmp;
      ctrl_next      = ctrl;
      hi_shadow_next = hi_shadow;

      if (ctrl[0]) begin
         presc_next = tick ? 16'd0 : (presc + 16'd1);
      end

      if (rd_commit && (offset == OFF_MTIME_LO)) begin
         hi_shadow_next = mtime[63:32];
      end

      if (wr_commit) begin
         case (offset)
            OFF_MTIME_LO: mtime_next[31:0] = merge_bytes(mtime_inc[31:0], in_pwdata, in_pstrb);
            OFF_MTIME_HI: begin
               mtime_next[63:32] = merge_bytes(mtime_inc[63:32], in_pwdata, in_pstrb);
               hi_shadow_next    = merge_bytes(hi_shadow, in_pwdata, in_pstrb);
            end
            OFF_CMP_LO:   mtimecmp_next[31:0]  = merge_bytes(mtimecmp[31:0], in_pwdata, in_pstrb);
            OFF_CMP_HI:   mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], in_pwdata, in_pstrb);
            OFF_CTRL: begin
               if (in_pstrb[0]) begin
                  ctrl_next = in_pwdata[1:0];
               end
            end
            default: begin
               ctrl_next = ctrl;
            end
         endcase
      end

      // Setting takes priority over a simultaneous clear
      pending_next = cmp_hit || (pending && !w1c);
   end

   // Timer and register state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc     <= 16'd0;
         mtime     <= 64'h0;
         mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
         ctrl      <= 2'b00;
         pending   <= 1'b0;
         hi_shadow <= 32'h0;
      end else begin
         presc     <= presc_next;
         mtime     <= mtime_next;
         mtimecmp  <= mtimecmp_next;
         ctrl      <= ctrl_next;
         pending   <= pending_next;
         hi_shadow <= hi_shadow_next;
      end
   end

   // Interrupt output, registered one cycle behind pending
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         irq <= 1'b0;
      end else begin
         irq <= pending && ctrl[1];
      end
   end

endmodule
